// File: rtl/ifetch.sv
// Instruction fetch: requests imem at pc, holds the returned word for decode, tracks accepts/faults.
// Latency: accept -> request next cycle -> valid one cycle after ack; decode stalls by holding instr_ready low.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        instr_ready,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_4,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] instr_count,
    output logic        misalign,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] to_cnt;
    logic       to_hit;

    // This cycle is the TIMEOUT-th consecutive FETCH cycle without an ack.
    assign to_hit = (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (imem_ack) begin
                    state_nxt = VALID;
                end else if (to_hit) begin
                    state_nxt = HALT;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_count <= 32'h0;
            to_cnt      <= 8'h0;
            misalign    <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr  <= imem_rdata;
                        to_cnt <= 8'h0;
                    end else if (to_hit) begin
                        fetch_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'h1;
                    end
                end
                VALID: begin
                    if (instr_ready) begin
                        pc          <= {npc[31:2], 2'b00};
                        instr_count <= instr_count + 32'h1;
                        if (npc[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are forced low for the whole reset cycle, not just after the edge.
    assign imem_req    = (state == FETCH) && !rst;
    assign instr_valid = (state == VALID) && !rst;
    assign imem_addr   = pc;
    assign pc_4        = pc + 32'h4;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 255, maximum FETCH cycles without imem_ack before fault; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 npc  input  32  next-PC from next-PC unit; sampled only on an accept.
REQ-006 instr_ready  input  1  decode stage accepts the presented instruction.
REQ-007 imem_ack  input  1  instruction memory returns imem_rdata this cycle.
REQ-008 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  32  fetch address; equals pc.
REQ-011 pc  output  32  address of the instruction held or being fetched.
REQ-012 pc_4  output  32  pc+4, modulo 2^32.
REQ-013 instr  output  32  latched instruction word.
REQ-014 instr_valid  output  1  instr/pc are valid for decode.
REQ-015 instr_count  output  32  number of accepted instructions, wraps at 2^32.
REQ-016 misalign  output  1  sticky; npc with nonzero [1:0] was accepted.
REQ-017 fetch_err  output  1  sticky; fetch timed out, block halted.

Function
REQ-018 States: FETCH, VALID, HALT; state register and all outputs update only on rising clk.
REQ-019 FETCH: imem_req=1, instr_valid=0; timeout counter increments each FETCH cycle without imem_ack.
REQ-020 FETCH with imem_ack=1 (including the first FETCH cycle): instr<=imem_rdata, counter<=0, next state VALID.
REQ-021 FETCH with counter reaching TIMEOUT and imem_ack=0: fetch_err<=1, next state HALT; ack in that same cycle takes priority (REQ-020).
REQ-022 imem_addr and pc SHALL be stable for every cycle imem_req=1 until imem_ack.
REQ-023 VALID: imem_req=0, instr_valid=1; instr, pc held unchanged while instr_ready=0.
REQ-024 VALID with instr_ready=1 (accept): pc<={npc[31:2],2'b00}, instr_count<=instr_count+1, next state FETCH.
REQ-025 Accept with npc[1:0]!=0 sets misalign<=1; fetch proceeds at aligned address.
REQ-026 npc=32'hFFFF_FFFC accepted as-is; pc_4 wraps to 0; npc=0 after 0xFFFFFFFC is legal.
REQ-027 instr_ready in FETCH or HALT ignored; imem_ack outside FETCH ignored.
REQ-028 HALT: imem_req=0, instr_valid=0, pc/instr/instr_count held; exit only by rst.
REQ-029 Latency: accept at edge N -> imem_req=1 with new address in cycle N+1; zero-wait ack -> instr_valid=1 in cycle N+2.

Reset
REQ-030 rst=1 at an edge: state<=FETCH, pc<=RESET_PC, instr<=0, instr_count<=0, timeout counter<=0, misalign<=0, fetch_err<=0.
REQ-031 imem_req and instr_valid SHALL be 0 in every cycle rst=1, regardless of state.
REQ-032 rst mid-fetch or mid-VALID abandons the transaction; ack arriving during rst is discarded.
REQ-033 First cycle after rst deasserts: imem_req=1, imem_addr=RESET_PC.

Verification
REQ-034 Reset release, imem_ack same cycle with rdata=32'h00500093 -> next cycle instr_valid=1, instr=32'h00500093, pc=0, pc_4=4.
REQ-035 instr_valid=1, instr_ready low 5 cycles then high with npc=32'h40 -> instr/pc stable 5 cycles; then imem_addr=32'h40, instr_count=1.
REQ-036 Accept with npc=32'h102 -> imem_addr=32'h100, misalign=1 and stays 1 after later aligned accepts.
REQ-037 pc=32'hFFFFFFFC: pc_4=0; accept npc=0 -> imem_addr=0.
REQ-038 TIMEOUT=3, imem_ack never asserted -> fetch_err=1 after 3rd FETCH cycle, imem_req=0 thereafter; ack then ignored; rst restores FETCH at RESET_PC.
REQ-039 rst asserted while in FETCH with ack same cycle -> instr stays 0, instr_valid=0, restart at RESET_PC.
